rca_ou_elastic_buffer: RTL

//  Elastic FIFO between two RCA operation units (OUs), on the OU output -> OU input path.

---
 rtl/rca_ou_elastic_buffer_pkg.sv | 5 +
 rtl/rca_ou_elastic_buffer.sv | 53 +++++
 2 files changed

// File: rtl/rca_ou_elastic_buffer_pkg.sv
// rca_ou_elastic_buffer_pkg: datapath width and uniform RCA buffer depth
package rca_ou_elastic_buffer_pkg;
  localparam int XLEN = 32;
  localparam int RCA_BUF_DEPTH = 4;
endpackage

// File: rtl/rca_ou_elastic_buffer.sv
// rca_ou_elastic_buffer: elastic FIFO on the OU output -> OU input path; ports: clk, rst (async active-low), flush, data_in/data_valid_in/data_in_ack (producer), data_out/data_valid_out/data_out_ack (consumer), occupancy/full/empty (status)
module rca_ou_elastic_buffer
  import rca_ou_elastic_buffer_pkg::*;
#(
  parameter int DEPTH = RCA_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [XLEN-1:0]            data_in,
  input  logic                       data_valid_in,
  output logic                       data_in_ack,
  output logic [XLEN-1:0]            data_out,
  output logic                       data_valid_out,
  input  logic                       data_out_ack,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);
  typedef logic [$clog2(DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH+1)-1:0] occ_t;
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);
  localparam occ_t FULL_OCC = occ_t'(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  ptr_t wr_ptr, rd_ptr;
  logic push, pop;
  assign full = occupancy == FULL_OCC;
  assign empty = occupancy == '0;
  // ack is gated by reset and never looks at data_out_ack, so a full buffer cannot pass a pop straight through
  assign push = rst && data_valid_in && !full && !flush;
  assign pop = data_valid_out && data_out_ack && !flush;
  assign data_in_ack = push;
  assign data_valid_out = !empty;
  assign data_out = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      occupancy <= occupancy + occ_t'(push) - occ_t'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= data_in;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) occupancy <= FULL_OCC);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(empty && pop));
endmodule
